// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain 8N1 UART transmitter:
// state encoding, line levels and the per-state tx level decode.
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_CAP   = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

  // Line level to present while the FSM sits in state st.
  function automatic logic tx_level(input logic [2:0] st, input logic data_bit);
    logic lvl;
    case (st)
      ST_START: lvl = START_LEVEL;
      ST_DATA:  lvl = data_bit;
      ST_STOP:  lvl = STOP_LEVEL;
      default:  lvl = UART_IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: o_tick marks the last cycle of every CLKS_PER_BIT-cycle bit,
// o_pre_tick the cycle before it. i_clr restarts the period from zero.
module fifo_uart_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST_CNT = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  // Period counter, wraps at the bit boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick     = (r_cnt == LAST_CNT);
  assign o_pre_tick = (r_cnt == PRE_LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one entry at a time and sends each byte as an 8N1 frame.
// All outputs come straight from flops, loaded from the next-state decode.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("fifo_uart_tx: DATA_BITS must be 8");
  end
  if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be 2..65535");
  end

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_nxt;
  logic       r_tx;
  logic       r_fifo_rd;
  logic       r_busy;
  logic       r_frame_done;
  logic       w_tick;
  logic       w_pre_tick;
  logic       w_baud_clr;
  logic       w_go;

  assign w_go       = enable & ~fifo_empty;
  assign w_baud_clr = (r_state == ST_CAP);

  fifo_uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (w_baud_clr),
    .o_tick    (w_tick),
    .o_pre_tick(w_pre_tick)
  );

  // Next-state, shift and bit-index decode; enable/empty only matter in IDLE and at end of STOP.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_CAP;
      end
      ST_CAP: begin
        w_state_nxt = ST_START;
        w_shift_nxt = fifo_dout;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == LAST_IDX) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_go) begin
            w_state_nxt = ST_RD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output flops; frame_done is loaded one cycle ahead of the final STOP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= 8'h00;
      r_bit_idx    <= 3'd0;
      r_tx         <= UART_IDLE_LEVEL;
      r_fifo_rd    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_tx         <= tx_level(w_state_nxt, w_shift_nxt[0]);
      r_fifo_rd    <= (w_state_nxt == ST_RD);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= (r_state == ST_STOP) && w_pre_tick;
    end
  end

  assign tx         = r_tx;
  assign fifo_rd    = r_fifo_rd;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO feeding the DUT, expected bytes queued at
// push time and checked by a line monitor that decodes every frame cycle by cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];

  int n_chk = 0;
  int n_err = 0;
  int ncyc = 0;
  int rd_count = 0;
  int fd_count = 0;
  int frames_seen = 0;
  logic       mon_active = 1'b0;
  int         mon_cyc = 0;
  logic       mon_ok = 1'b1;
  logic [7:0] mon_exp = 8'h00;
  logic [7:0] mon_got = 8'h00;
  logic [7:0] last_byte = 8'h00;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  // Behavioural FIFO: registered dout and empty flag.
  initial begin
    forever begin
      @(posedge clk);
      if (wr_en) fifo_q.push_back(wr_data);
      if (fifo_rd && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Line monitor: pops the expected byte at each start bit and checks every cycle of the frame.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (fifo_rd) begin
          rd_count++;
          check("rd_nonempty", 32'(fifo_empty), 32'd0);
        end
        if (frame_done) fd_count++;
        if (!mon_active) begin
          if (tx == 1'b0) begin
            mon_active = 1'b1;
            mon_cyc = 0;
            mon_ok = 1'b1;
            mon_got = 8'h00;
            start_q.push_back(ncyc);
            if (exp_q.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL unexpected_frame: actual=start at %0d required=no frame", ncyc);
              mon_exp = 8'h00;
            end else begin
              mon_exp = exp_q.pop_front();
            end
          end
        end else begin
          mon_cyc++;
        end
        if (mon_active) begin
          if (tx !== line_bit(mon_exp, mon_cyc)) mon_ok = 1'b0;
          if (frame_done !== (mon_cyc == FRAME_CYC - 1)) mon_ok = 1'b0;
          if ((mon_cyc % CPB) == CPB / 2 && mon_cyc / CPB >= 1 && mon_cyc / CPB <= 8)
            mon_got[mon_cyc / CPB - 1] = tx;
          if (mon_cyc == FRAME_CYC - 1) begin
            check("frame_timing", 32'(mon_ok), 32'd1);
            check("frame_byte", 32'(mon_got), 32'(mon_exp));
            last_byte = mon_got;
            frames_seen++;
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      tick();
      n++;
    end
    check("frames_reached", 32'(frames_seen), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_rd, base_fd, base_fr, n0, rd_at, tx_at, n;
    logic ok;
    rst_n = 1'b0;
    enable = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Empty FIFO with enable high.
    enable = 1'b1;
    base_rd = rd_count;
    ok = 1'b1;
    repeat (100) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) ok = 1'b0;
    end
    check("idle_empty_quiet", 32'(ok), 32'd1);
    check("idle_empty_no_rd", 32'(rd_count - base_rd), 32'd0);

    // Single byte 0xA5: latency, line pattern, frame_done.
    base_rd = rd_count;
    base_fd = fd_count;
    base_fr = frames_seen;
    push_byte(8'hA5);
    tick();
    check("a5_empty_fall", 32'(fifo_empty), 32'd0);
    rd_at = -1;
    tx_at = -1;
    for (int k = 1; k <= 10 && tx_at < 0; k++) begin
      tick();
      if (fifo_rd && rd_at < 0) rd_at = k;
      if (tx == 1'b0) tx_at = k;
    end
    check("a5_rd_offset", 32'(rd_at), 32'd1);
    check("a5_tx_fall_latency", 32'(tx_at), 32'd3);
    wait_frames(base_fr + 1, 60);
    repeat (2) tick();
    check("a5_byte", 32'(last_byte), 32'hA5);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_rd_pulses", 32'(rd_count - base_rd), 32'd1);
    check("a5_done_pulses", 32'(fd_count - base_fd), 32'd1);

    // Back-to-back 0x00, 0xFF.
    base_rd = rd_count;
    base_fr = frames_seen;
    n0 = start_q.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(base_fr + 2, 130);
    repeat (3) tick();
    check("b2b_start_spacing",
          32'((start_q.size() >= n0 + 2) ? start_q[n0+1] - start_q[n0] : -1), 32'd42);
    check("b2b_rd_pulses", 32'(rd_count - base_rd), 32'd2);
    check("b2b_last_byte", 32'(last_byte), 32'hFF);
    check("b2b_empty", 32'(fifo_empty), 32'd1);
    check("b2b_busy", 32'(busy), 32'd0);

    // enable dropped during START of the first of three bytes.
    base_rd = rd_count;
    base_fr = frames_seen;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("hold_in_start", 32'(tx), 32'd0);
    enable = 1'b0;
    wait_frames(base_fr + 1, 60);
    repeat (20) tick();
    check("hold_byte", 32'(last_byte), 32'h11);
    check("hold_frames", 32'(frames_seen - base_fr), 32'd1);
    check("hold_rd_pulses", 32'(rd_count - base_rd), 32'd1);
    check("hold_fifo_level", 32'(fifo_q.size()), 32'd2);
    check("hold_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_frames(base_fr + 3, 150);
    repeat (3) tick();
    check("resume_last_byte", 32'(last_byte), 32'h33);
    check("resume_rd_pulses", 32'(rd_count - base_rd), 32'd3);

    // Full FIFO 0x01..0x08.
    enable = 1'b0;
    base_rd = rd_count;
    base_fr = frames_seen;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("full_level", 32'(fifo_q.size()), 32'd8);
    enable = 1'b1;
    wait_frames(base_fr + 8, 8 * 44 + 40);
    repeat (3) tick();
    check("full_rd_pulses", 32'(rd_count - base_rd), 32'd8);
    check("full_last_byte", 32'(last_byte), 32'h08);
    check("full_empty", 32'(fifo_empty), 32'd1);
    check("full_busy", 32'(busy), 32'd0);

    // Reset during DATA bit 3 of 0x55.
    base_fr = frames_seen;
    push_byte(8'h55);
    n = 0;
    while (!(mon_active && mon_cyc == CPB + 3 * CPB + 1) && n < 40) begin
      tick();
      n++;
    end
    check("mid_bit3_level", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd", 32'(fifo_rd), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    base_rd = rd_count;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("post_rst_idle", 32'(ok), 32'd1);
    check("post_rst_no_rd", 32'(rd_count - base_rd), 32'd0);
    check("post_rst_no_frame", 32'(frames_seen - base_fr), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-deep byte FIFO. Pops one byte at a time through the FIFO's read/dout/empty interface and serializes it as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit) on a single tx line. Sits between the FIFO and the board pin; one instance per FIFO.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; fixed at 8 to match FIFO width. Any other value is a synthesis-time error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  1  1 = drain FIFO and transmit; 0 = finish current frame, then hold idle
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  8  FIFO registered read data; valid the cycle after a read is sampled
fifo_rd  output  1  FIFO read strobe; one-cycle pulse per byte
tx  output  1  serial line, idle high, registered
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse in the last cycle of STOP

Behaviour:
- Reset (rst_n=0, async): state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0. Takes effect immediately, including mid-frame. tx returns high without completing the frame. A popped byte not yet sent is lost.
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low. Deassertion is synchronous to clk upstream.
- FSM states: IDLE, RD, CAP, START, DATA, STOP.
- IDLE: if enable=1 and fifo_empty=0 -> RD. Otherwise stay.
- RD: fifo_rd=1 for exactly this one cycle (decoded from the state register, glitch-free) -> CAP. fifo_empty is not re-checked here.
- CAP: capture fifo_dout into an 8-bit shift register at the closing edge; clear the baud counter -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit boundary. After bit index 7 -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. At the end of STOP:
  - if enable=1 and fifo_empty=0 -> RD (back-to-back frames);
  - else -> IDLE.
- Inter-frame gap for back-to-back frames is exactly 2 idle-high cycles (RD, CAP) after the stop bit.
- Frame length from entering START to leaving STOP is 10*CLKS_PER_BIT cycles.
- Latency from IDLE with a non-empty FIFO and enable=1 to the tx falling edge is 3 cycles (RD, CAP, then first START cycle).
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit index is 3 bits and wraps 7 -> exit DATA.
- tx is driven from a flop. No combinational path from any input to tx.
- enable deasserted mid-frame: the current frame completes normally, then IDLE. enable is sampled only in IDLE and at the end of STOP.
- fifo_empty is sampled only in IDLE and at the end of STOP. It rising during a frame has no effect.
- At most one fifo_rd per frame. fifo_rd is never asserted while fifo_empty=1 at the sampling cycle.
- Simultaneous enable rise and fifo_empty fall in IDLE: RD on the next cycle.

Decomposition:
- Shared package: state encoding constants (IDLE..STOP), UART_IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- Natural sub-module: uart_baud_tick, a counter producing a one-cycle bit_tick every CLKS_PER_BIT cycles. It has a synchronous clear driven by the FSM in CAP.
- The FSM, shift register and bit index stay in fifo_uart_tx.

Test Plan:
- Reset mid-frame, CLKS_PER_BIT=4: assert rst_n=0 during DATA bit 3 -> tx=1, busy=0, fifo_rd=0 in the same cycle. After release, stays IDLE with an empty FIFO.
- Single byte 0xA5, CLKS_PER_BIT=4, with the easy_fifo model:
  - one fifo_rd pulse; tx falls 3 cycles later;
  - line reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - frame_done pulses once, in cycle 40 of the frame; then IDLE, busy=0.
- Back-to-back 0x00 then 0xFF: two frames separated by exactly 2 high cycles. Exactly 2 fifo_rd pulses total. Final fifo_empty=1 and state IDLE.
- enable dropped at START of the 1st of 3 queued bytes (0x11, 0x22, 0x33): only the 0x11 frame is sent. FIFO keeps 2 entries, no further fifo_rd. Re-raising enable sends 0x22 then 0x33.
- Empty FIFO with enable=1 for 100 cycles -> fifo_rd never asserted, tx constantly 1, busy=0.
- FIFO filled to 8 (full) with 0x01..0x08 -> 8 frames in order, LSB first. fifo_empty asserts after the 8th fifo_rd. Decoded bytes match 0x01..0x08.
